rs485_tx_frame: RTL and testbench

Half-duplex RS485 frame transmitter with driver-enable (DE) sequencing. It accepts bytes over a valid/ready handshake and serialises them as 8N1 UART frames on `rs485_tx`. It asserts `rs485_de` with a programmable lead time before the start bit and holds it for a programmable lag after the stop bit, so the transceiver never truncates a frame. It sits between on-chip message logic and the board RS485 transceiver pins, one instance per port, all sharing the differential-buffered `sys_clk`.

---
 rtl/rs485_pkg.sv | 29 ++
 rtl/rs485_bit_timer.sv | 37 +++
 rtl/rs485_tx_frame.sv | 220 ++++++++++++++++++++++
 tb/tb_rs485_tx_frame.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/rs485_pkg.sv
// Shared types and constants for the RS485 frame transmitter.
// Parity support in rs485_tx_frame is enabled by defining RS485_TX_PARITY_EN.
package rs485_pkg;

  localparam int DATA_BITS = 8;
  localparam int LAG_CNT_W = 4;

  // ST_PAR is only ever entered when RS485_TX_PARITY_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_PAR   = 3'd4,
    ST_STOP  = 3'd5,
    ST_LAG   = 3'd6
  } rs485_tx_state_t;

  // Truncated number of sys_clk cycles per bit.
  function automatic int calc_cycle_bit(input int clk_fre_mhz, input int baud_rate);
    return (clk_fre_mhz * 1000000) / baud_rate;
  endfunction

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rs485_bit_timer.sv
// Free-running bit-period down-counter; bit_tick_o marks the last cycle of
// each bit. restart_i realigns the period to the following cycle.
module rs485_bit_timer
  import rs485_pkg::*;
#(
  parameter int CYCLE_BIT = 1736
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic bit_tick_o
);

  localparam int CNT_W = cnt_width(CYCLE_BIT);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CYCLE_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (restart_i || (cnt_q == '0)) begin
      cnt_d = RELOAD;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick_o = (cnt_q == '0);

endmodule

// File: rtl/rs485_tx_frame.sv
// Half-duplex RS485 8N1 transmitter with driver-enable lead/lag sequencing.
// Define RS485_TX_PARITY_EN to append an even-parity bit (8E1 framing).
//
// Handshake: a byte transfers on a rising sys_clk edge where tx_data_valid
// and tx_data_ready are both 1; tx_data_ready is a flop, high only in IDLE
// and LAG, and tx_data is ignored whenever tx_data_ready is low.
module rs485_tx_frame
  import rs485_pkg::*;
#(
  parameter int CLK_FRE        = 200,
  parameter int BAUD_RATE      = 115200,
  parameter int DE_LEAD_CYCLES = 16,
  parameter int DE_LAG_BITS    = 1
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_data_valid,
  output logic                 tx_data_ready,
  output logic                 tx_busy,
  output logic                 rs485_tx,
  output logic                 rs485_de,
  output rs485_tx_state_t      dbg_state_o
);

  localparam int CYCLE_BIT = calc_cycle_bit(CLK_FRE, BAUD_RATE);
  localparam int LEAD_W    = cnt_width(DE_LEAD_CYCLES);
  localparam logic [LEAD_W-1:0] LEAD_RELOAD =
    LEAD_W'((DE_LEAD_CYCLES > 0) ? DE_LEAD_CYCLES - 1 : 0);
  localparam logic [LAG_CNT_W-1:0] LAG_RELOAD =
    LAG_CNT_W'((DE_LAG_BITS > 0) ? DE_LAG_BITS - 1 : 0);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  rs485_tx_state_t        state_q, state_d;
  logic                   tx_q, tx_d;
  logic                   de_q, de_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [LEAD_W-1:0]      lead_cnt_q, lead_cnt_d;
  logic [LAG_CNT_W-1:0]   lag_cnt_q, lag_cnt_d;
`ifdef RS485_TX_PARITY_EN
  logic                   par_q, par_d;
`endif

  logic xfer;
  logic restart;
  logic bit_tick;

  assign xfer = tx_data_valid && ready_q;

  rs485_bit_timer #(
    .CYCLE_BIT (CYCLE_BIT)
  ) u_bit_timer (
    .clk_i      (sys_clk),
    .rst_ni     (rst_n),
    .restart_i  (restart),
    .bit_tick_o (bit_tick)
  );

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    de_d       = de_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    lead_cnt_d = lead_cnt_q;
    lag_cnt_d  = lag_cnt_q;
    restart    = 1'b0;
`ifdef RS485_TX_PARITY_EN
    par_d      = par_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          shift_d = tx_data;
`ifdef RS485_TX_PARITY_EN
          par_d   = ^tx_data;
`endif
          de_d    = 1'b1;
          if (DE_LEAD_CYCLES == 0) begin
            state_d = ST_START;
            tx_d    = 1'b0;
            restart = 1'b1;
          end else begin
            state_d    = ST_LEAD;
            lead_cnt_d = LEAD_RELOAD;
          end
        end
      end

      ST_LEAD: begin
        if (lead_cnt_q == '0) begin
          state_d = ST_START;
          tx_d    = 1'b0;
          restart = 1'b1;
        end else begin
          lead_cnt_d = lead_cnt_q - 1'b1;
        end
      end

      ST_START: begin
        if (bit_tick) begin
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = '0;
        end
      end

      ST_DATA: begin
        if (bit_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
`ifdef RS485_TX_PARITY_EN
            state_d = ST_PAR;
            tx_d    = par_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

`ifdef RS485_TX_PARITY_EN
      ST_PAR: begin
        if (bit_tick) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif

      ST_STOP: begin
        if (bit_tick) begin
          if (DE_LAG_BITS == 0) begin
            state_d = ST_IDLE;
            de_d    = 1'b0;
          end else begin
            state_d   = ST_LAG;
            lag_cnt_d = LAG_RELOAD;
          end
        end
      end

      // A byte offered during the lag starts immediately: DE is already up,
      // so no lead time is inserted.
      ST_LAG: begin
        if (xfer) begin
          shift_d = tx_data;
`ifdef RS485_TX_PARITY_EN
          par_d   = ^tx_data;
`endif
          state_d = ST_START;
          tx_d    = 1'b0;
          restart = 1'b1;
        end else if (bit_tick) begin
          if (lag_cnt_q == '0) begin
            state_d = ST_IDLE;
            de_d    = 1'b0;
          end else begin
            lag_cnt_d = lag_cnt_q - 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        de_d    = 1'b0;
      end
    endcase

    ready_d = (state_d == ST_IDLE) || (state_d == ST_LAG);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tx_q       <= 1'b1;
      de_q       <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      lead_cnt_q <= '0;
      lag_cnt_q  <= '0;
`ifdef RS485_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      de_q       <= de_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      lead_cnt_q <= lead_cnt_d;
      lag_cnt_q  <= lag_cnt_d;
`ifdef RS485_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign tx_data_ready = ready_q;
  assign tx_busy       = busy_q;
  assign rs485_tx      = tx_q;
  assign rs485_de      = de_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_rs485_tx_frame.sv
// Directed bench for rs485_tx_frame: instance A uses lead 16 / lag 1,
// instance B lead 0 / lag 0; both at 20 MHz / 115200 baud (173 cycles per bit).
module tb_rs485_tx_frame;
  import rs485_pkg::*;

  localparam int CLK_FRE = 20;
  localparam int BAUD    = 115200;
  localparam int C       = 173;   // 20e6 / 115200 = 173.6, truncated
  localparam int A_LEAD  = 16;
  localparam int A_LAG   = 1;
  localparam int BUDGET  = 30 * C;

  logic sys_clk;
  logic a_rst_n, b_rst_n;
  logic [7:0] a_data, b_data;
  logic a_valid, b_valid;
  logic a_rdy, a_busy, a_tx, a_de;
  logic b_rdy, b_busy, b_tx, b_de;
  rs485_tx_state_t a_state, b_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  rs485_tx_frame #(
    .CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD), .DE_LEAD_CYCLES(A_LEAD), .DE_LAG_BITS(A_LAG)
  ) dut_a (
    .sys_clk(sys_clk), .rst_n(a_rst_n), .tx_data(a_data), .tx_data_valid(a_valid),
    .tx_data_ready(a_rdy), .tx_busy(a_busy), .rs485_tx(a_tx), .rs485_de(a_de),
    .dbg_state_o(a_state)
  );

  rs485_tx_frame #(
    .CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD), .DE_LEAD_CYCLES(0), .DE_LAG_BITS(0)
  ) dut_b (
    .sys_clk(sys_clk), .rst_n(b_rst_n), .tx_data(b_data), .tx_data_valid(b_valid),
    .tx_data_ready(b_rdy), .tx_busy(b_busy), .rs485_tx(b_tx), .rs485_de(b_de),
    .dbg_state_o(b_state)
  );

  // Clock and reset
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // {tx, de, ready, busy}
  function automatic logic [3:0] obs(input bit sel);
    return sel ? {b_tx, b_de, b_rdy, b_busy} : {a_tx, a_de, a_rdy, a_busy};
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // Expects the same output vector for n consecutive cycles, starting at the
  // current sample point; reports the first deviating value.
  task automatic seg(input bit sel, input string tag, input logic [3:0] exp, input int n);
    logic [3:0] seen;
    bit bad;
    bad  = 1'b0;
    seen = obs(sel);
    for (int i = 0; i < n; i++) begin
      if (!bad) seen = obs(sel);
      if (seen !== exp) bad = 1'b1;
      @(posedge sys_clk); #1;
    end
    check(tag, {4'h0, seen}, {4'h0, exp});
  endtask

  // Driver: waits for ready, offers one byte for exactly one transfer edge.
  task automatic send(input bit sel, input logic [7:0] d, input bit hold, input bit push);
    int t;
    t = 0;
    while (!(sel ? b_rdy : a_rdy) && t < BUDGET) begin
      @(posedge sys_clk); #1;
      t++;
    end
    if (t >= BUDGET) check("ready_wait", {7'h0, (sel ? b_rdy : a_rdy)}, 8'h01);
    if (sel) begin b_data = d; b_valid = 1'b1; end
    else     begin a_data = d; a_valid = 1'b1; end
    if (push) exp_q.push_back(d);
    @(posedge sys_clk); #1;
    if (!hold) begin
      if (sel) begin b_valid = 1'b0; b_data = 8'($urandom_range(0, 255)); end
      else     begin a_valid = 1'b0; a_data = 8'($urandom_range(0, 255)); end
    end
  endtask

  // Scoreboard side: pops the expected byte and walks the whole frame.
  task automatic check_frame(input bit sel, input bit with_lead, input int lead,
                             input int lag_bits, input bit next_xfer);
    logic [7:0] b;
    string pfx;
    pfx = sel ? "B" : "A";
    if (exp_q.size() == 0) begin
      check({pfx, " scoreboard_underflow"}, 8'h00, 8'h01);
      return;
    end
    b = exp_q.pop_front();
    if (with_lead && lead > 0) seg(sel, $sformatf("%s lead 0x%02h", pfx, b), 4'b1101, lead);
    seg(sel, $sformatf("%s start 0x%02h", pfx, b), 4'b0101, C);
    for (int i = 0; i < 8; i++)
      seg(sel, $sformatf("%s bit%0d 0x%02h", pfx, i, b), {b[i], 3'b101}, C);
`ifdef RS485_TX_PARITY_EN
    seg(sel, $sformatf("%s parity 0x%02h", pfx, b), {^b, 3'b101}, C);
`endif
    seg(sel, $sformatf("%s stop 0x%02h", pfx, b), 4'b1101, C);
    if (lag_bits > 0) begin
      if (next_xfer) begin
        seg(sel, $sformatf("%s lag_first 0x%02h", pfx, b), 4'b1111, 1);
        return;
      end
      seg(sel, $sformatf("%s lag 0x%02h", pfx, b), 4'b1111, lag_bits * C);
    end
    seg(sel, $sformatf("%s idle_after 0x%02h", pfx, b), 4'b1010, 1);
  endtask

  initial begin
    logic [7:0] rnd;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_data  = 8'h00; b_data = 8'h00;

    // Reset: outputs at reset values, ready rises one cycle after release
    repeat (10) @(posedge sys_clk);
    #1;
    check("A in_reset", {4'h0, obs(0)}, 8'h08);
    check("B in_reset", {4'h0, obs(1)}, 8'h08);
    check("A state_reset", 8'(a_state), 8'(ST_IDLE));
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    #1;
    check("A after_release", {4'h0, obs(0)}, 8'h08);
    @(posedge sys_clk); #1;
    check("A ready_1cyc", {4'h0, obs(0)}, 8'h0A);
    check("B ready_1cyc", {4'h0, obs(1)}, 8'h0A);
    check("B state_idle", 8'(b_state), 8'(ST_IDLE));

    // Single byte with lead and lag
    send(0, 8'h55, 1'b0, 1'b1);
    check_frame(0, 1'b1, A_LEAD, A_LAG, 1'b0);

    // Back-to-back: second byte offered during first frame, held valid
    send(0, 8'hA5, 1'b1, 1'b1);
    a_data = 8'h3C;
    exp_q.push_back(8'h3C);
    check_frame(0, 1'b1, A_LEAD, A_LAG, 1'b1);
    a_valid = 1'b0;
    check("A b2b_state", 8'(a_state), 8'(ST_START));
    check_frame(0, 1'b0, A_LEAD, A_LAG, 1'b0);

    // Zero lead / zero lag instance
    send(1, 8'hFF, 1'b0, 1'b1);
    check_frame(1, 1'b1, 0, 0, 1'b0);
    rnd = 8'($urandom_range(0, 255));
    send(1, rnd, 1'b0, 1'b1);
    check_frame(1, 1'b1, 0, 0, 1'b0);

    // Parity case byte (8N1 unless the parity macro is defined)
    send(0, 8'h07, 1'b0, 1'b1);
    check_frame(0, 1'b1, A_LEAD, A_LAG, 1'b0);

    // Reset in the middle of bit 4 of 0x0F
    send(0, 8'h0F, 1'b0, 1'b0);
    seg(0, "A abort lead", 4'b1101, A_LEAD);
    seg(0, "A abort start", 4'b0101, C);
    for (int i = 0; i < 4; i++) seg(0, $sformatf("A abort bit%0d", i), 4'b1101, C);
    seg(0, "A abort bit4_half", 4'b0101, C / 2);
    a_rst_n = 1'b0;
    #1;
    check("A async_reset", {4'h0, obs(0)}, 8'h08);
    check("A async_state", 8'(a_state), 8'(ST_IDLE));
    repeat (3) @(posedge sys_clk);
    #1;
    a_rst_n = 1'b1;
    send(0, 8'h96, 1'b0, 1'b1);
    check_frame(0, 1'b1, A_LEAD, A_LAG, 1'b0);

    check("scoreboard_empty", 8'(exp_q.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
